// File: rtl/code_loader_pkg.sv
// code_loader_pkg: loader state encodings and size constants shared by the loader.
// Rev 1.0
`default_nettype none

package code_loader_pkg;

  localparam int LD_MAX_WORDS = 512;
  localparam int LD_LEN_W     = 10;

  typedef enum logic [3:0] {
    LD_IDLE    = 4'd0,
    LD_LEN_HI  = 4'd1,
    LD_LEN_LO  = 4'd2,
    LD_DATA_HI = 4'd3,
    LD_DATA_LO = 4'd4,
    LD_WRITE   = 4'd5,
    LD_CSUM    = 4'd6,
    LD_RUN     = 4'd7,
    LD_ERROR   = 4'd8
  } ld_state_e;

  // States in which a stream byte can be consumed.
  function automatic logic ld_takes_byte(input ld_state_e s);
    case (s)
      LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CSUM: ld_takes_byte = 1'b1;
      default:                                               ld_takes_byte = 1'b0;
    endcase
  endfunction

  function automatic logic ld_in_frame(input ld_state_e s);
    ld_in_frame = ld_takes_byte(s) || (s == LD_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_loader.sv
// code_loader: frames a length-prefixed byte stream into 16-bit code-memory writes,
// verifies an XOR checksum and raises run on success. Rev 1.0
`default_nettype none

module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = LD_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [WORD_W-1:0] code_in,
  output logic              run,
  output logic              busy,
  output logic              error,
  output logic [9:0]        words_loaded
);

  ld_state_e             state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [LD_LEN_W-1:0]   len_q, len_d;
  logic [LD_LEN_W-1:0]   words_q, words_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            hi_q, hi_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0]     code_q, code_d;

  logic                  accept;
  logic [15:0]           len_full;
  logic [LD_LEN_W-1:0]   words_inc;

  assign rx_ready     = ld_takes_byte(state_q) & ~load;
  assign accept       = rx_valid & rx_ready;
  assign len_full     = {len_hi_q, rx_data};
  assign words_inc    = words_q + LD_LEN_W'(1);

  assign code_w_en    = w_en_q;
  assign code_addr_in = addr_q;
  assign code_in      = code_q;
  assign run          = (state_q == LD_RUN);
  assign error        = (state_q == LD_ERROR);
  assign busy         = ld_in_frame(state_q);
  assign words_loaded = words_q;

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    words_d  = words_q;
    csum_d   = csum_q;
    hi_d     = hi_q;
    w_en_d   = w_en_q;
    addr_d   = addr_q;
    code_d   = code_q;

    if (load) begin
      state_d  = LD_LEN_HI;
      len_hi_d = '0;
      len_d    = '0;
      words_d  = '0;
      csum_d   = '0;
      hi_d     = '0;
      w_en_d   = 1'b0;
      addr_d   = '0;
      code_d   = '0;
    end else begin
      case (state_q)
        LD_LEN_HI: begin
          if (accept) begin
            len_hi_d = rx_data;
            state_d  = LD_LEN_LO;
          end
        end
        LD_LEN_LO: begin
          if (accept) begin
            if (len_full == 16'd0) begin
              state_d = LD_CSUM;
            end else if (len_full > 16'(MAX_WORDS)) begin
              state_d = LD_ERROR;
            end else begin
              len_d   = len_full[LD_LEN_W-1:0];
              state_d = LD_DATA_HI;
            end
          end
        end
        LD_DATA_HI: begin
          if (accept) begin
            hi_d    = rx_data;
            csum_d  = csum_q ^ rx_data;
            state_d = LD_DATA_LO;
          end
        end
        LD_DATA_LO: begin
          // Strobe, address and word are registered so they are stable for the WRITE cycle.
          if (accept) begin
            csum_d  = csum_q ^ rx_data;
            w_en_d  = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            code_d  = WORD_W'({hi_q, rx_data});
            state_d = LD_WRITE;
          end
        end
        LD_WRITE: begin
          w_en_d  = 1'b0;
          words_d = words_inc;
          state_d = (words_inc == len_q) ? LD_CSUM : LD_DATA_HI;
        end
        LD_CSUM: begin
          if (accept) begin
            state_d = (rx_data == csum_q) ? LD_RUN : LD_ERROR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LD_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      csum_q   <= '0;
      hi_q     <= '0;
      w_en_q   <= 1'b0;
      addr_q   <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      words_q  <= words_d;
      csum_q   <= csum_d;
      hi_q     <= hi_d;
      w_en_q   <= w_en_d;
      addr_q   <= addr_d;
      code_q   <= code_d;
    end
  end

endmodule

`default_nettype wire
